// File: rtl/fwb_pkg.sv
// Shared types and constants for the frame write buffer: FSM states, count width helper, default frame size.
package fwb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  localparam int FB_WORDS_DEFAULT = 307200;

  // Occupancy needs one extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/frame_write_buffer_if.sv
// Processor write port and frame-buffer write port of the buffer; master drives writes and grant, slave is the buffer.
interface frame_write_buffer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              fb_grant;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  modport master (
    output wr_en, wr_addr, wr_data, fb_grant,
    input  wr_full, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, fb_grant,
    output wr_full, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/fwb_fifo.sv
// Synchronous FIFO, head visible combinationally; push lands the next cycle.
// Caller must not push when full nor pop when empty; pointers wrap modulo DEPTH.
module fwb_fifo
  import fwb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 27
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            push_dat,
  input  logic                    pop,
  output logic [W-1:0]            head_dat,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/frame_write_buffer.sv
// Queues pixel writes and drains them to the frame buffer on fb_grant; hardware clear mode, range/overflow flags.
// Push to fb_we is two cycles with grant held; wr_full backpressures the processor. FWB_STATS_EN adds hwm/drop_cnt.
module frame_write_buffer
  import fwb_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int FB_WORDS = FB_WORDS_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  frame_write_buffer_if.slave     bus,
  input  logic                    clear_req,
  input  logic [DATA_W-1:0]       clear_color,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    bad_addr,
  input  logic                    flag_clr
`ifdef FWB_STATS_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] hwm,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int                CW       = cnt_w(DEPTH);
  localparam int                EW       = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   FB_LIM   = (ADDR_W+1)'(FB_WORDS);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

  state_t            state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              addr_ok;
  logic              push;
  logic              pop;
  logic              clear_go;
  logic              clear_pend;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;

  assign addr_ok     = ({1'b0, bus.wr_addr} < FB_LIM);
  assign push        = bus.wr_en && !fifo_full && addr_ok;
  assign clear_go    = (state == IDLE) && (clear_req || clear_pend);
  // IDLE pops too, so a lone write reaches fb_we without waiting for the DRAIN transition.
  assign pop         = (state != CLEAR) && !clear_go && !fifo_empty && bus.fb_grant;
  assign bus.wr_full = fifo_full;

  fwb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat ({bus.wr_addr, bus.wr_data}),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      clear_pend  <= 1'b0;
      clr_addr    <= '0;
      clr_color   <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
    end else begin
      bus.fb_we  <= 1'b0;
      clear_done <= 1'b0;
      if (pop) begin
        bus.fb_we                  <= 1'b1;
        {bus.fb_addr, bus.fb_data} <= head;
      end
      case (state)
        IDLE: begin
          if (clear_go) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_addr   <= '0;
            clear_pend <= 1'b0;
            if (clear_req) clr_color <= clear_color;
          end else if (!fifo_empty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (clear_req) begin
            clear_pend <= 1'b1;
            clr_color  <= clear_color;
          end
          if (fifo_empty || (pop && !push && count == CW'(1))) state <= IDLE;
        end
        CLEAR: begin
          if (bus.fb_grant) begin
            bus.fb_we   <= 1'b1;
            bus.fb_addr <= clr_addr;
            bus.fb_data <= clr_color;
            if (clr_addr == CLR_LAST) begin
              clear_done <= 1'b1;
              clear_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // flag_clr wins over a same-cycle set event.
  always_ff @(posedge clock) begin
    if (reset || flag_clr) begin
      overflow <= 1'b0;
      bad_addr <= 1'b0;
    end else begin
      if (bus.wr_en && fifo_full) overflow <= 1'b1;
      if (bus.wr_en && !addr_ok)  bad_addr <= 1'b1;
    end
  end

`ifdef FWB_STATS_EN
  logic drop;
  assign drop = bus.wr_en && (fifo_full || !addr_ok);

  always_ff @(posedge clock) begin
    if (reset || flag_clr) begin
      hwm      <= '0;
      drop_cnt <= '0;
    end else begin
      if (count > hwm) hwm <= count;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/frame_write_buffer.md
Name: frame_write_buffer

Overview:
Parametrised successor to the direct processor-store-to-VGA-index-RAM path. Queues processor pixel writes in a synchronous FIFO and drains them to the frame-buffer write port only while the display side grants access, i.e. during blanking. Adds a hardware clear-screen mode and range and overflow checking. Sits between the processor's memory-write outputs and the frame-buffer RAM write port, clocked by the VGA control clock.

Parameters:
ADDR_W, 19, frame-buffer word address width
DATA_W, 8, pixel/index data width
DEPTH, 16, FIFO entries; power of two, minimum 2
FB_WORDS, 307200, valid frame-buffer words (640x480); must satisfy FB_WORDS <= 2**ADDR_W

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  processor write strobe, one write per cycle
wr_addr  in  ADDR_W  pixel address
wr_data  in  DATA_W  pixel data
wr_full  out  1  FIFO full; processor must hold off
clear_req  in  1  single-cycle pulse: fill the frame buffer with clear_color
clear_color  in  DATA_W  fill value, sampled on clear_req
clear_busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse when the clear completes
fb_grant  in  1  frame-buffer write slot available this cycle
fb_we  out  1  frame-buffer write enable (registered)
fb_addr  out  ADDR_W  frame-buffer write address (registered)
fb_data  out  DATA_W  frame-buffer write data (registered)
count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a write arrived while wr_full was asserted
bad_addr  out  1  sticky: a write had wr_addr >= FB_WORDS
flag_clr  in  1  clears overflow and bad_addr

Behaviour:
- Reset: FIFO emptied. All outputs are 0 at reset: fb_we, fb_addr, fb_data, count, wr_full, clear_busy, clear_done, overflow and bad_addr. State is IDLE. Reset asserted mid-clear aborts the clear with no clear_done pulse.
- Push: occurs when wr_en=1, wr_full=0 and wr_addr < FB_WORDS.
  - wr_en while full: write dropped, overflow set.
  - Out-of-range address: write dropped, bad_addr set, not pushed.
  - wr_full is computed from the current count only. A push while full is rejected even if a pop occurs in the same cycle.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- flag_clr has priority over a set event in the same cycle.
- States:
  - IDLE: on clear_req, latch clear_color, set clear address to 0, go to CLEAR. Otherwise, if the FIFO is non-empty, go to DRAIN.
  - DRAIN: on each cycle with fb_grant=1, pop the FIFO head and register it to fb_addr/fb_data with fb_we=1 on the next cycle. Return to IDLE when the FIFO empties. clear_req in DRAIN is honoured at the next IDLE visit; a request pending flag holds it.
  - CLEAR: clear_busy=1. On each cycle with fb_grant=1, write clear_color to the clear address and increment the address. After address FB_WORDS-1 is written, pulse clear_done and go to IDLE.
    - The FIFO still accepts pushes during CLEAR but does not drain.
    - clear_req during CLEAR is ignored.
- Latency: push in cycle N, fb_grant held high: fb_we=1 in cycle N+2 (one cycle to register into the FIFO, one output register). The bench checks this exact latency.
- fb_we is 0 in every cycle that does not follow a granted pop or clear write. fb_addr/fb_data hold their last value when fb_we=0.
- FIFO pointers wrap modulo DEPTH. The clear address never exceeds FB_WORDS-1.

Optional Feature:
FWB_STATS_EN:
- Defined: adds output hwm ($clog2(DEPTH)+1 bits), the FIFO high-water mark, and output drop_cnt (16 bits), which counts dropped writes (overflow plus bad address) and saturates at 16'hFFFF. Both are cleared by reset and by flag_clr.
- Undefined: neither port nor the logic exists; all other behaviour is identical.

Decomposition:
- Package fwb_pkg holds:
  - state typedef (IDLE, DRAIN, CLEAR)
  - function computing count width from DEPTH
  - default FB_WORDS constant
- One sub-module, fwb_fifo: synchronous FIFO with push/pop, full/empty and count, parametrised on DEPTH and the entry width ADDR_W+DATA_W.

Test Plan:
- Single write addr=0x00010, data=0x5A, fb_grant=1: fb_we=1 with fb_addr=0x00010, fb_data=0x5A exactly 2 cycles after the push; count returns to 0.
- fb_grant=0, 17 writes with DEPTH=16: wr_full=1 after the 16th; the 17th is dropped; overflow=1, count=16. Raise fb_grant: 16 writes appear in order, one per cycle.
- Write with wr_addr=307200: no fb_we, bad_addr=1, count=0; flag_clr drops bad_addr to 0.
- clear_req with clear_color=0x03, FB_WORDS overridden to 8, fb_grant toggling 1/0: 8 writes to addresses 0..7 of 0x03, then a single clear_done pulse; queued pushes drain only after the clear.
- Reset asserted during CLEAR at address 4: all outputs 0 next cycle, no clear_done, FIFO empty.
- FWB_STATS_EN defined: 3 overflow drops plus 2 bad-address drops give drop_cnt=5; hwm equals the peak count reached.
